// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: small FIFO of {instruction, pc} pairs between fetch and decode.
// A taken branch (flush) discards every stored entry; reset clears pointers and occupancy.
// Optional macro FETCH_QUEUE_BYPASS_EN: when the queue is empty, the fetch input is
// forwarded straight to the decoder in the same cycle. If it is consumed there, it is not stored.
module instr_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int PC_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_instr,
  output logic [PC_W-1:0]  out_pc,
  input  logic             out_ready,
  input  logic             flush,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [31+PC_W:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic             empty;
  logic             bypass;
  logic             push_wr;
  logic             pop_fifo;
  logic [31+PC_W:0] head;

  // Handshake, bypass decision and head selection
  always_comb begin
    empty    = (count_q == '0);
    in_ready = (count_q != FULL_CNT);
`ifdef FETCH_QUEUE_BYPASS_EN
    // Bypass is suppressed by flush and while reset is asserted.
    bypass   = empty && in_valid && !flush && !rst;
`else
    bypass   = 1'b0;
`endif
    // A bypassed entry that the decoder takes this cycle never lands in storage.
    push_wr  = in_valid && in_ready && !flush && !(bypass && out_ready);
    pop_fifo = !empty && out_ready;
    head     = mem_q[rd_ptr_q];
    out_valid = !empty || bypass;
    out_instr = '0;
    out_pc    = '0;
    if (bypass) begin
      out_instr = in_instr;
      out_pc    = in_pc;
    end else if (!empty) begin
      out_instr = head[31+PC_W:PC_W];
      out_pc    = head[PC_W-1:0];
    end
    count = count_q;
  end

  // Next-state for pointers and occupancy; flush wins over push and pop
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_wr)  wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_fifo) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_wr, pop_fifo})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are not cleared, occupancy alone marks them live
  always_ff @(posedge clk) begin
    if (push_wr) mem_q[wr_ptr_q] <= {in_instr, in_pc};
  end

endmodule
